am74ls259_scan: RTL and testbench
=================================

// Module: am74ls259_scan
// PURPOSE
//  Clocked 8-bit addressable latch (74LS259 function) plus optional scan sequencer.
//  It is the receiving end of an 8-to-1 mux: it drives select lines to an external
//  am74ls251, samples its y output and assembles the 8 inputs into a parallel word.
//  Used wherever a bit-selected or serialized status bus must be returned to parallel form.
// PARAMETERS
//  SETTLE   2       clocks held on each select value before y_in is sampled (1..15)
//  QRESET   8'h00   value loaded into q by rst
// PORTS
//  clk         in   1  rising-edge clock; the only clock
//  rst         in   1  reset; synchronous, active-high
//  d           in   1  manual data bit
//  a,b,c       in   1  manual bit address; c is the MSB, so addr = {c,b,a}
//  g_          in   1  manual enable, active-low
//  clr_        in   1  manual clear, active-low
//  q           out  8  latched parallel word
//  scan_start  in   1  request a full 8-bit scan (sampled only in IDLE)
//  y_in        in   1  y output of the external mux
//  sel_a,sel_b,sel_c  out 1  select lines driven to the external mux; sel_c is the MSB
//  scan_busy   out  1  high from the accepted start until the cycle before scan_done
//  scan_done   out  1  one-cycle pulse; q already holds the new word in that cycle
// BEHAVIOUR
//  Reset: q=QRESET, sel=3'b000, scan_busy=0, scan_done=0, FSM=IDLE. Reset applies
//   mid-scan too; the partial shadow word is discarded.
//  Manual modes, applied at the clk edge when the FSM is IDLE or DONE:
//   clr_=1 g_=0  addressable latch: q[addr]<=d, all other q bits hold
//   clr_=1 g_=1  memory: q holds
//   clr_=0 g_=0  demux: q<=0 except q[addr]<=d
//   clr_=0 g_=1  clear: q<=0
//  FSM states: IDLE -> SETUP -> SAMPLE -> (SETUP | DONE) -> IDLE
//   IDLE:   scan_start=1 -> SETUP; sel<=0; settle counter<=SETTLE-1; shadow<=0.
//   SETUP:  counts down the settle counter; at 0 -> SAMPLE.
//   SAMPLE: shadow[sel]<=y_in. If sel==7 -> DONE. Otherwise sel<=sel+1,
//           counter reloads, -> SETUP.
//   DONE:   q<=shadow; scan_done=1; sel<=0; -> IDLE.
//  Latency: scan_done asserts 8*(SETTLE+1)+1 edges after the edge that samples scan_start.
//  scan_start while busy or in DONE is ignored; there is no queuing.
//  While busy, manual latch, memory and demux writes are ignored.
//   Manual clear (clr_=0 g_=1) aborts the scan: q<=0, FSM->IDLE, no scan_done pulse.
//  Simultaneous DONE and manual write in the same cycle: the scan result wins.
//  sel wraps only via DONE -> 0; sel never exceeds 7.
// CONFIGURATION
//  AM74LS259_SCAN_EN defined: the scan sequencer is built as described above.
//  AM74LS259_SCAN_EN undefined: the sequencer is removed. scan_start and y_in are
//   ignored; sel_a/b/c, scan_busy and scan_done are tied to 0. Manual modes act on
//   every clock.
// STRUCTURE
//  Package am74ls_pkg holds:
//   - mode constants LATCH, MEMORY, DEMUX, CLEAR, decoded from {clr_,g_}
//   - scan FSM state encoding IDLE, SETUP, SAMPLE, DONE
//   - the SETTLE range limits
//  Sub-module am74ls259_core: the clocked addressable latch (modes plus write-port mux).
//   The top level adds the FSM, settle counter, shadow register and arbitration.
// TESTING
//  1 rst=1, then release -> q=8'h00, sel=0, busy=0, done=0.
//  2 Latch mode, write d=1 to addr 5, then d=1 to addr 0 -> q=8'h21.
//    Then g_=1 -> q holds 8'h21.
//  3 Demux mode with addr 3, d=1 -> q=8'h08.
//    Then clear mode -> q=8'h00.
//  4 Scan, SETTLE=2, with a behavioural 251 model holding 8'hA5 -> scan_done after
//    exactly 25 edges; q=8'hA5; sel stepped 0..7 with 3 clocks on each value.
//  5 Second scan_start mid-scan -> ignored; single done pulse.
//    Manual latch write mid-scan -> ignored; q=8'hA5 at done.
//  6 rst asserted at sel=4 mid-scan -> FSM IDLE, q=QRESET, no done pulse.
//    Clear-abort mid-scan -> q=0, no done pulse.
//    Rebuild with AM74LS259_SCAN_EN undefined -> scan ports stay 0; scenarios 1-3 pass.

Source files
------------

// File: rtl/am74ls_pkg.sv
// am74ls_pkg: shared types and constants for the am74ls259_scan block.
//   mode_t        manual operating mode, encoded directly as {clr_, g_}
//   scan_state_t  scan sequencer state encoding
//   SETTLE_MIN/MAX  legal range of the settle-time parameter
//   decode_mode() turns the two active-low control pins into a mode_t
package am74ls_pkg;

  typedef enum logic [1:0] {
    DEMUX  = 2'b00,  // clr_=0 g_=0
    CLEAR  = 2'b01,  // clr_=0 g_=1
    LATCH  = 2'b10,  // clr_=1 g_=0
    MEMORY = 2'b11   // clr_=1 g_=1
  } mode_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    SAMPLE = 2'b10,
    DONE   = 2'b11
  } scan_state_t;

  localparam int SETTLE_MIN = 1;
  localparam int SETTLE_MAX = 15;
  localparam int CNT_W      = 4;   // wide enough for SETTLE_MAX-1

  function automatic mode_t decode_mode(input logic clr_n, input logic g_n);
    return mode_t'({clr_n, g_n});
  endfunction

endpackage

// File: rtl/am74ls259_core.sv
// am74ls259_core: clocked 8-bit addressable latch (74LS259 function).
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset (q <= QRESET)
//   d, addr[2:0]  data bit and bit address for latch/demux modes
//   mode[1:0]     {clr_, g_} as decoded by am74ls_pkg::mode_t
//   manual_en     when low, the manual mode is not applied this edge
//   load_en       parallel load of load_val; overrides any manual mode
//   load_val[7:0] parallel word (scan result)
//   q[7:0]        latched word
module am74ls259_core
  import am74ls_pkg::*;
#(
  parameter logic [7:0] QRESET = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       d,
  input  logic [2:0] addr,
  input  logic [1:0] mode,
  input  logic       manual_en,
  input  logic       load_en,
  input  logic [7:0] load_val,
  output logic [7:0] q
);

  mode_t mode_e;
  assign mode_e = mode_t'(mode);

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= QRESET;
    end else if (load_en) begin
      q <= load_val;
    end else if (manual_en) begin
      case (mode_e)
        LATCH:   q[addr] <= d;
        DEMUX:   q       <= 8'(d) << addr;
        CLEAR:   q       <= 8'h00;
        default: q       <= q;          // MEMORY
      endcase
    end
  end

endmodule

// File: rtl/am74ls259_scan.sv
// am74ls259_scan: addressable latch plus optional scan sequencer that walks an
// external am74ls251 8-to-1 mux and assembles its y output into q.
// Build option: define AM74LS259_SCAN_EN to build the scan sequencer; without it
// scan_start/y_in are ignored and the scan outputs are tied to 0.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   d, a, b, c, g_, clr_   manual 74LS259 interface, addr = {c,b,a}
//   q[7:0]                 latched parallel word
//   scan_start, y_in       scan request and external mux output
//   sel_a, sel_b, sel_c    mux select lines, sel_c is the MSB
//   scan_busy, scan_done   busy flag and one-cycle completion pulse
module am74ls259_scan
  import am74ls_pkg::*;
#(
  parameter int         SETTLE = 2,       // SETTLE_MIN..SETTLE_MAX
  parameter logic [7:0] QRESET = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       d,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       g_,
  input  logic       clr_,
  output logic [7:0] q,
  input  logic       scan_start,
  input  logic       y_in,
  output logic       sel_a,
  output logic       sel_b,
  output logic       sel_c,
  output logic       scan_busy,
  output logic       scan_done
);

  mode_t      mode;
  logic       manual_en;
  logic       load_en;
  logic [7:0] load_val;

  assign mode = decode_mode(clr_, g_);

`ifdef AM74LS259_SCAN_EN

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE - 1);

  scan_state_t      state_q, state_d;
  logic [2:0]       sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       shadow_q, shadow_d;
  logic             done_d;
  logic             scanning;

  // SETUP/SAMPLE lock out manual writes; DONE lets them through but the
  // parallel load of the scan result takes priority inside the core.
  assign scanning  = (state_q == SETUP) || (state_q == SAMPLE);
  assign manual_en = !scanning || (mode == CLEAR);

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the case leaves a signal unassigned and infers a latch.
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    done_d   = 1'b0;
    load_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (scan_start) begin
          state_d  = SETUP;
          sel_d    = 3'd0;
          cnt_d    = RELOAD;
          shadow_d = 8'h00;
        end
      end
      SETUP: begin
        if (cnt_q == '0) state_d = SAMPLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      SAMPLE: begin
        shadow_d[sel_q] = y_in;
        if (sel_q == 3'd7) begin
          state_d = DONE;
        end else begin
          sel_d   = sel_q + 3'd1;
          cnt_d   = RELOAD;
          state_d = SETUP;
        end
      end
      DONE: begin
        load_en = 1'b1;
        done_d  = 1'b1;
        sel_d   = 3'd0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A manual clear during the active scan abandons it without a done pulse.
    if (scanning && mode == CLEAR) begin
      state_d = IDLE;
      sel_d   = 3'd0;
    end
  end

  // NOTE: the shadow word is reset along with the control state; it is only
  // eight flops and this keeps its contents deterministic after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= 3'd0;
      cnt_q     <= '0;
      shadow_q  <= 8'h00;
      scan_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      scan_done <= done_d;
    end
  end

  assign load_val  = shadow_q;
  assign scan_busy = (state_q != IDLE);
  assign {sel_c, sel_b, sel_a} = sel_q;

`else

  logic unused_scan;
  assign unused_scan = scan_start ^ y_in;

  assign manual_en = 1'b1;
  assign load_en   = 1'b0;
  assign load_val  = 8'h00;
  assign sel_a     = 1'b0;
  assign sel_b     = 1'b0;
  assign sel_c     = 1'b0;
  assign scan_busy = 1'b0;
  assign scan_done = 1'b0;

`endif

  am74ls259_core #(
    .QRESET (QRESET)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .d         (d),
    .addr      ({c, b, a}),
    .mode      (mode),
    .manual_en (manual_en),
    .load_en   (load_en),
    .load_val  (load_val),
    .q         (q)
  );

endmodule

// File: tb/tb_am74ls259_scan.sv
// tb_am74ls259_scan: directed bench for am74ls259_scan with a q-word scoreboard.
// Stimulus pushes expected words; a monitor on the falling edge pops and compares
// them when the bench strobes a manual observation or the DUT pulses scan_done.
module tb_am74ls259_scan;

  logic       clk = 1'b0;
  logic       rst, d, a, b, c, g_, clr_, scan_start;
  logic       sel_a, sel_b, sel_c, scan_busy, scan_done, y_in;
  logic [7:0] q;
  logic [7:0] pattern;
  logic [2:0] sel_v;
  logic       obs;

  int total = 0;
  int bad   = 0;
  int done_seen = 0;

  typedef struct {
    string      name;
    logic [7:0] val;
  } exp_t;

  exp_t obs_exp[$];
  exp_t done_exp[$];

  always #5 clk = ~clk;

  assign sel_v = {sel_c, sel_b, sel_a};
  assign y_in  = pattern[sel_v];   // behavioural am74ls251

  am74ls259_scan #(
    .SETTLE (2),
    .QRESET (8'h00)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .d          (d),
    .a          (a),
    .b          (b),
    .c          (c),
    .g_         (g_),
    .clr_       (clr_),
    .q          (q),
    .scan_start (scan_start),
    .y_in       (y_in),
    .sel_a      (sel_a),
    .sel_b      (sel_b),
    .sel_c      (sel_c),
    .scan_busy  (scan_busy),
    .scan_done  (scan_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares scoreboard entries against q when an output is presented.
  always @(negedge clk) begin
    if (obs) begin
      if (obs_exp.size() == 0) check("obs_underflow", 1, 0);
      else begin
        exp_t e;
        e = obs_exp.pop_front();
        check(e.name, {24'h0, q}, {24'h0, e.val});
      end
    end
    if (scan_done) begin
      done_seen++;
      if (done_exp.size() == 0) check("unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = done_exp.pop_front();
        check(e.name, {24'h0, q}, {24'h0, e.val});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_q(input string name, input logic [7:0] val);
    obs_exp.push_back('{name, val});
    obs = 1'b1;
    @(negedge clk);
    #1 obs = 1'b0;
  endtask

  // One manual operation for a single edge, then back to memory mode.
  task automatic manual(input logic clr_n, input logic g_n, input logic [2:0] addr, input logic dv);
    clr_ = clr_n; g_ = g_n; {c, b, a} = addr; d = dv;
    tick();
    clr_ = 1'b1; g_ = 1'b1; d = 1'b0;
  endtask

  task automatic start_scan();
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; d = 1'b0; {c, b, a} = 3'd0; g_ = 1'b1; clr_ = 1'b1;
    scan_start = 1'b0; pattern = 8'h00; obs = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // 1: reset state
    check("reset_q", {24'h0, q}, 32'h00);
    check("reset_sel", {29'h0, sel_v}, 32'd0);
    check("reset_busy", {31'h0, scan_busy}, 32'd0);
    check("reset_done", {31'h0, scan_done}, 32'd0);

    // 2: addressable latch and memory
    manual(1'b1, 1'b0, 3'd5, 1'b1);
    manual(1'b1, 1'b0, 3'd0, 1'b1);
    expect_q("latch_21", 8'h21);
    repeat (2) tick();
    expect_q("memory_hold", 8'h21);
    manual(1'b1, 1'b0, 3'd7, 1'b1);
    expect_q("latch_msb_set", 8'hA1);
    manual(1'b1, 1'b0, 3'd0, 1'b0);
    expect_q("latch_lsb_clr", 8'hA0);

    // 3: demux and clear
    manual(1'b0, 1'b0, 3'd3, 1'b1);
    expect_q("demux_08", 8'h08);
    manual(1'b0, 1'b1, 3'd0, 1'b0);
    expect_q("clear_00", 8'h00);

`ifdef AM74LS259_SCAN_EN
    // 4: full scan, 3 clocks per select value, done 25 edges after start
    pattern = 8'hA5;
    done_exp.push_back('{"scan_a5", 8'hA5});
    start_scan();
    for (int k = 0; k < 25; k++) begin
      check($sformatf("sel_step%0d", k), {29'h0, sel_v}, (k / 3 > 7) ? 32'd7 : 32'(k / 3));
      check($sformatf("busy_step%0d", k), {31'h0, scan_busy}, 32'd1);
      check($sformatf("early_done%0d", k), {31'h0, scan_done}, 32'd0);
      tick();
    end
    check("done_at_25", {31'h0, scan_done}, 32'd1);
    check("busy_at_done", {31'h0, scan_busy}, 32'd0);
    tick();
    check("done_count_1", done_seen, 1);
    check("sel_after_done", {29'h0, sel_v}, 32'd0);

    // 5: restart ignored, manual write ignored while busy
    manual(1'b0, 1'b1, 3'd0, 1'b0);
    expect_q("clear_pre5", 8'h00);
    done_exp.push_back('{"scan_ignore", 8'hA5});
    start_scan();
    for (int k = 1; k <= 25; k++) begin
      if (k == 5) scan_start = 1'b1;
      if (k == 8) begin g_ = 1'b0; {c, b, a} = 3'd1; d = 1'b1; end
      tick();
      scan_start = 1'b0; g_ = 1'b1; d = 1'b0;
      if (k == 9) check("midscan_q_held", {24'h0, q}, 32'h00);
    end
    tick();
    check("done_count_2", done_seen, 2);

    // scan result wins over a manual write in the DONE cycle
    pattern = 8'h5A;
    done_exp.push_back('{"scan_wins", 8'h5A});
    start_scan();
    repeat (24) tick();
    manual(1'b1, 1'b0, 3'd0, 1'b1);
    tick();
    expect_q("after_done_hold", 8'h5A);
    check("done_count_3", done_seen, 3);

    // 6a: reset mid-scan
    pattern = 8'hFF;
    start_scan();
    repeat (12) tick();
    check("sel_before_rst", {29'h0, sel_v}, 32'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_q", {24'h0, q}, 32'h00);
    check("rst_mid_busy", {31'h0, scan_busy}, 32'd0);
    check("rst_mid_sel", {29'h0, sel_v}, 32'd0);
    repeat (30) tick();

    // 6b: clear aborts mid-scan
    manual(1'b1, 1'b0, 3'd7, 1'b1);
    expect_q("latch_pre_abort", 8'h80);
    start_scan();
    repeat (5) tick();
    manual(1'b0, 1'b1, 3'd0, 1'b0);
    check("abort_q", {24'h0, q}, 32'h00);
    check("abort_busy", {31'h0, scan_busy}, 32'd0);
    repeat (30) tick();
    check("done_count_final", done_seen, 3);
`else
    // Sequencer absent: scan ports stay 0 and manual modes still work.
    pattern = 8'hFF;
    scan_start = 1'b1;
    repeat (10) tick();
    check("noscan_sel", {29'h0, sel_v}, 32'd0);
    check("noscan_busy", {31'h0, scan_busy}, 32'd0);
    manual(1'b1, 1'b0, 3'd2, 1'b1);
    expect_q("noscan_latch", 8'h04);
    repeat (20) tick();
    check("noscan_done", done_seen, 0);
    check("noscan_q", {24'h0, q}, 32'h04);
    scan_start = 1'b0;
`endif

    check("pending_done", done_exp.size(), 0);
    check("pending_obs", obs_exp.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
